ct_block_writer: RTL and testbench
==================================

Name: ct_block_writer

Overview:
- Downstream of the AES cipher core and upstream of the dual-port block RAM that the QSPI slave reads.
- Captures each 128-bit ciphertext block on the cipher's one-cycle done pulse and buffers up to 2 blocks, because the cipher has no backpressure.
- Serialises each block into 16 byte writes on RAM port A, packing blocks into a ring of 16-byte slots.
- Reports a written-block count and a sticky overflow flag for software polling.

Parameters:
- ADDR_W, 8, RAM port-A address width; ring holds 2^(ADDR_W-4) block slots (16 at default).
- BUF_DEPTH, 2, block buffer entries, including the block currently being written; legal values 1..4.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst  in  1  synchronous, active-high reset.
- blk_valid  in  1  single-cycle pulse: blk_data holds a new ciphertext block.
- blk_data  in  128  ciphertext block.
- ptr_clr  in  1  pulse: restart the ring at slot 0 and zero blk_cnt.
- ovf_clr  in  1  pulse: clear the overflow flag.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_data  out  8  RAM write data.
- blk_cnt  out  ADDR_W-4  slot index of the next block to be written; equals completed blocks mod 2^(ADDR_W-4).
- busy  out  1  high while the buffer is non-empty.
- overflow  out  1  sticky: at least one block was dropped.

Behaviour:
- Reset state: ram_we=0, ram_addr=0, ram_data=0, blk_cnt=0, busy=0, overflow=0, buffer empty, FSM in IDLE.
- Byte order is MSB first. Byte k of a block is blk_data[127-8k -: 8] and goes to address {slot, k[3:0]}.
- FSM has two states, IDLE and WRITE.
- IDLE to WRITE: when the buffer is non-empty.
- In WRITE, one byte is issued per cycle, with ram_we=1, for k=0..15.
- Latency: blk_valid in cycle t while IDLE and empty gives the first ram_we in cycle t+1 (k=0) and the last in cycle t+16.
- After k=15, the entry is popped and blk_cnt increments (wrapping at 2^(ADDR_W-4)).
- If another entry is waiting, its k=0 write is issued in the very next cycle, with no bubble. Otherwise the FSM returns to IDLE and ram_we=0.
- Push rule: blk_valid is accepted if occupancy < BUF_DEPTH.
- Simultaneous push and pop: blk_valid in the same cycle as the k=15 write of a full buffer is accepted.
- A blk_valid that arrives when the buffer is full and no pop occurs that cycle is dropped, and overflow is set the next cycle.
- overflow stays set until ovf_clr or rst. If ovf_clr and a drop occur in the same cycle, the set wins.
- ptr_clr in IDLE sets blk_cnt=0.
- ptr_clr in WRITE aborts the current block and flushes the buffer; blk_cnt=0 and ram_we=0 the next cycle.
- ptr_clr together with blk_valid: the clear applies first, then the new block is pushed into the empty buffer and written to slot 0.
- rst mid-block: the write stops immediately (ram_we=0 the next cycle) and all state returns to reset values. Partially written RAM contents are not repaired.
- ram_addr and ram_data are registered and hold their last values while ram_we=0.

Optional Feature:
- Macro: CT_XOR_CHECK_EN.
- When defined, two extra output ports are added:
  - blk_chk [7:0]: XOR of the 16 bytes of the block.
  - blk_chk_valid: one-cycle pulse in the cycle after the k=15 write. blk_chk holds its value until the next pulse. Both reset to 0.
- An aborted block (ptr_clr or rst) produces no pulse.
- When not defined, these ports and the checksum logic are absent. All other behaviour is identical.

Decomposition:
- Shared package aes_pkg holds:
  - constant BLK_BYTES=16;
  - constant BLK_W=128;
  - the FSM state enum {ST_IDLE, ST_WRITE};
  - a byte-index type of 4 bits.
- Sub-module ct_blk_fifo is the BUF_DEPTH x 128 synchronous FIFO, with push, pop, full, empty and count, and same-cycle push/pop when full. The parent holds the FSM, the byte counter and the address/flag logic.

Test Plan:
- Single block: one blk_valid with blk_data=128'h00112233_44556677_8899AABB_CCDDEEFF. Expect ram_we in cycles t+1..t+16, addr 0x00..0x0F, data 00,11,...,FF. Then blk_cnt=1 and busy=0.
- Back-to-back: 2 pulses 5 cycles apart. Expect 32 consecutive writes to 0x00..0x1F with no gap, blk_cnt=2 and overflow=0.
- Overflow: 3 pulses in cycles 0, 1 and 2 with BUF_DEPTH=2. The third is dropped: overflow=1 from cycle 3, and only 32 writes occur. ovf_clr then drives overflow=0.
- Pop/push edge: with the buffer full, a pulse coincides with the k=15 write. It is accepted, writes total 48, and overflow=0.
- Wrap: 17 blocks, spaced 20 cycles apart. Block 16 is written at 0x00..0x0F and blk_cnt=1 afterwards.
- Abort: ptr_clr at k=7 of block 0, then a new block. ram_we drops the next cycle, the new block is written at 0x00, and with CT_XOR_CHECK_EN the new block's blk_chk equals the XOR of its bytes (e.g. 8'h00 for the 00..FF pattern above).

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: block/byte constants, writer FSM states and byte helper shared by the ciphertext path.
// Rev 1.0
`default_nettype none

package aes_pkg;

  localparam int BLK_BYTES = 16;
  localparam int BLK_W     = 128;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  typedef logic [3:0] byte_idx_t;

  // Byte k counted from the MSB end of the block.
  function automatic logic [7:0] blk_byte(input logic [BLK_W-1:0] blk, input byte_idx_t k);
    logic [BLK_W-1:0] s;
    s = blk << {k, 3'b000};
    return s[BLK_W-1 -: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ct_blk_fifo.sv
// ct_blk_fifo: DEPTH x 128 block FIFO with flush, same-cycle push/pop and a look-ahead head.
// Rev 1.0
`default_nettype none

module ct_blk_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [BLK_W-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [BLK_W-1:0] o_nxt_head,
  output logic             o_nxt_empty
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BLK_W-1:0] r_mem [2**c_PW];
  logic [c_PW-1:0]  r_rd;
  logic [c_PW-1:0]  r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;
  logic             w_push;
  logic             w_last;

  function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign w_last  = (r_cnt == CW'(1));
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign w_push  = i_push && (!o_full || w_pop || i_flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= w_push ? ptr_inc('0) : '0;
      r_cnt <= CW'(w_push);
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[i_flush ? '0 : r_wr] <= i_din;
  end

  // Head as it will be after this edge; bypasses i_din when that entry is being written now.
  always_comb begin
    o_nxt_head = r_mem[r_rd];
    if (i_flush || (w_pop ? w_last : o_empty)) o_nxt_head = i_din;
    else if (w_pop)                            o_nxt_head = r_mem[ptr_inc(r_rd)];
  end

  assign o_nxt_empty = i_flush ? !w_push
                               : ((o_empty && !w_push) || (w_last && w_pop && !w_push));

endmodule

`default_nettype wire

// File: rtl/ct_block_writer.sv
// ct_block_writer: buffers AES ciphertext blocks and writes them MSB-first into a RAM slot ring.
// Optional checksum outputs with CT_XOR_CHECK_EN. Rev 1.0
`default_nettype none

module ct_block_writer
  import aes_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid,
  input  logic [127:0]      blk_data,
  input  logic              ptr_clr,
  input  logic              ovf_clr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic [ADDR_W-5:0] blk_cnt,
  output logic              busy,
  output logic              overflow
`ifdef CT_XOR_CHECK_EN
  ,
  output logic [7:0]        blk_chk,
  output logic              blk_chk_valid
`endif
);

  localparam int        c_SLOT_W = ADDR_W - 4;
  localparam int        c_CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam byte_idx_t c_LAST   = byte_idx_t'(BLK_BYTES - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  byte_idx_t           r_k;
  byte_idx_t           w_k_nxt;
  logic [c_SLOT_W-1:0] r_cnt;
  logic [c_SLOT_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_data;
  logic                r_ovf;
  logic                w_full;
  logic                w_empty;
  logic [c_CNT_W-1:0]  w_count;
  logic [BLK_W-1:0]    w_nxt_head;
  logic                w_nxt_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  assign w_pop  = (r_state == ST_WRITE) && (r_k == c_LAST) && !ptr_clr && !w_empty;
  assign w_push = blk_valid && (ptr_clr || !w_full || w_pop);
  assign w_drop = blk_valid && !w_push;

  ct_blk_fifo #(.DEPTH(BUF_DEPTH), .CW(c_CNT_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (ptr_clr),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_din      (blk_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count),
    .o_nxt_head (w_nxt_head),
    .o_nxt_empty(w_nxt_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    if (ptr_clr) begin
      w_state_nxt = w_nxt_empty ? ST_IDLE : ST_WRITE;
      w_k_nxt     = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_k_nxt = '0;
          if (!w_nxt_empty) w_state_nxt = ST_WRITE;
        end
        ST_WRITE: begin
          w_k_nxt = r_k + 1'b1;
          if (r_k == c_LAST && w_nxt_empty) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_k_nxt     = '0;
        end
      endcase
    end
  end

  assign w_cnt_nxt = ptr_clr ? '0 : (w_pop ? r_cnt + 1'b1 : r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_cnt   <= w_cnt_nxt;
      // Address/data are prepared one cycle ahead so the byte lands with ram_we.
      if (w_state_nxt == ST_WRITE) begin
        r_addr <= {w_cnt_nxt, w_k_nxt};
        r_data <= blk_byte(w_nxt_head, w_k_nxt);
      end
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign ram_we   = (r_state == ST_WRITE);
  assign ram_addr = r_addr;
  assign ram_data = r_data;
  assign blk_cnt  = r_cnt;
  assign busy     = (w_count != '0);
  assign overflow = r_ovf;

`ifdef CT_XOR_CHECK_EN
  logic [7:0] r_acc;
  logic [7:0] r_chk;
  logic       r_chk_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_chk     <= '0;
      r_chk_vld <= 1'b0;
    end else begin
      r_chk_vld <= w_pop;
      if (ram_we) r_acc <= ((r_k == '0) ? 8'h00 : r_acc) ^ r_data;
      if (w_pop)  r_chk <= r_acc ^ r_data;
    end
  end

  assign blk_chk       = r_chk;
  assign blk_chk_valid = r_chk_vld;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ct_block_writer.sv
// tb_ct_block_writer: queue-based reference model of the block writer plus directed and random traffic.
`default_nettype none

module tb_ct_block_writer;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2;
  localparam int NS     = 16;
  localparam logic [127:0] PAT = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         ptr_clr;
  logic         ovf_clr;
  logic         ram_we;
  logic [7:0]   ram_addr;
  logic [7:0]   ram_data;
  logic [3:0]   blk_cnt;
  logic         busy;
  logic         overflow;
`ifdef CT_XOR_CHECK_EN
  logic [7:0]   blk_chk;
  logic         blk_chk_valid;
`endif

  ct_block_writer #(.ADDR_W(ADDR_W), .BUF_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .blk_valid(blk_valid),
    .blk_data (blk_data),
    .ptr_clr  (ptr_clr),
    .ovf_clr  (ovf_clr),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .blk_cnt  (blk_cnt),
    .busy     (busy),
    .overflow (overflow)
`ifdef CT_XOR_CHECK_EN
    ,
    .blk_chk      (blk_chk),
    .blk_chk_valid(blk_chk_valid)
`endif
  );

  always #10 clk = ~clk;

  int vec  = 0;
  int errs = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] blk, input int k);
    logic [127:0] t;
    t = blk >> (8 * (15 - k));
    return t[7:0];
  endfunction

  function automatic logic [7:0] xor16(input logic [127:0] blk);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 16; k++) x ^= byte_of(blk, k);
    return x;
  endfunction

  // Reference model: queue of held blocks, current byte position (-1 = nothing being written).
  logic [127:0] mq[$];
  int           mpos = -1;
  int           mcnt = 0;
  bit           movf = 0;
  logic [7:0]   maddr = 0;
  logic [7:0]   mdata = 0;
  logic [7:0]   mchk = 0;
  bit           mchkv = 0;

  always @(posedge clk) begin : model_blk
    bit drop;
    drop = 0;
    if (rst) begin
      mq.delete();
      mpos = -1; mcnt = 0; movf = 0; maddr = 0; mdata = 0; mchk = 0; mchkv = 0;
    end else begin
      mchkv = 0;
      if (ptr_clr) begin
        mq.delete();
        mpos = -1;
        mcnt = 0;
      end else if (mpos == 15) begin
        mchk  = xor16(mq[0]);
        mchkv = 1;
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % NS;
        mpos = -1;
      end else if (mpos >= 0) begin
        mpos++;
      end
      if (blk_valid) begin
        if (mq.size() < DEPTH) mq.push_back(blk_data);
        else drop = 1;
      end
      if (drop) movf = 1;
      else if (ovf_clr) movf = 0;
      if (mpos < 0 && mq.size() > 0) mpos = 0;
      if (mpos >= 0) begin
        maddr = 8'(mcnt * 16 + mpos);
        mdata = byte_of(mq[0], mpos);
      end
    end
  end

  // Compare process and RAM image capture.
  logic [7:0] img [256];
  int         wr_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      check("ram_we", 32'(ram_we), 32'(mpos >= 0));
      check("ram_addr", 32'(ram_addr), 32'(maddr));
      check("ram_data", 32'(ram_data), 32'(mdata));
      check("blk_cnt", 32'(blk_cnt), 32'(mcnt));
      check("busy", 32'(busy), 32'(mq.size() > 0));
      check("overflow", 32'(overflow), 32'(movf));
`ifdef CT_XOR_CHECK_EN
      check("chk_valid", 32'(blk_chk_valid), 32'(mchkv));
      check("blk_chk", 32'(blk_chk), 32'(mchk));
`endif
    end
    if (ram_we === 1'b1) begin
      img[ram_addr] = ram_data;
      wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [127:0] d);
    blk_data  = d;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic clr();
    ptr_clr = 1'b1;
    tick();
    ptr_clr = 1'b0;
  endtask

  int base;
  logic [127:0] rb;

  initial begin
    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; ptr_clr = 1'b0; ovf_clr = 1'b0;
    tick();
    started = 1;
    repeat (2) tick();
    check("rst_we", 32'(ram_we), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_cnt", 32'(blk_cnt), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    tick();

    // Single block with fixed pattern and latency pins
    base = wr_cnt;
    pulse(PAT);
    check("lat_first_we", 32'(ram_we), 1);
    check("lat_first_data", 32'(ram_data), 32'h00);
    repeat (15) tick();
    check("lat_last_addr", 32'(ram_addr), 32'h0F);
    check("lat_last_data", 32'(ram_data), 32'hFF);
    tick();
    check("lat_after_we", 32'(ram_we), 0);
    repeat (4) tick();
    check("single_writes", 32'(wr_cnt - base), 16);
    check("single_img7", 32'(img[7]), 32'h77);
    check("single_cnt", 32'(blk_cnt), 1);
    check("single_busy", 32'(busy), 0);

    // Back-to-back
    clr();
    base = wr_cnt;
    pulse({$urandom, $urandom, $urandom, $urandom});
    repeat (4) tick();
    rb = {$urandom, $urandom, $urandom, $urandom};
    pulse(rb);
    repeat (40) tick();
    check("b2b_writes", 32'(wr_cnt - base), 32);
    check("b2b_img10", 32'(img[8'h10]), 32'(byte_of(rb, 0)));
    check("b2b_cnt", 32'(blk_cnt), 2);
    check("b2b_ovf", 32'(overflow), 0);

    // Overflow: three consecutive pulses
    clr();
    base = wr_cnt;
    blk_valid = 1'b1;
    blk_data = PAT;
    repeat (3) tick();
    blk_valid = 1'b0;
    check("ovf_set", 32'(overflow), 1);
    repeat (40) tick();
    check("ovf_writes", 32'(wr_cnt - base), 32);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 0);

    // Push coinciding with the k=15 write of a full buffer
    clr();
    base = wr_cnt;
    blk_data = PAT;
    blk_valid = 1'b1;
    repeat (2) tick();
    blk_valid = 1'b0;
    repeat (14) tick();
    pulse(PAT);
    repeat (60) tick();
    check("edge_writes", 32'(wr_cnt - base), 48);
    check("edge_ovf", 32'(overflow), 0);
    check("edge_cnt", 32'(blk_cnt), 3);

    // Wrap around the 16-slot ring
    clr();
    base = wr_cnt;
    for (int i = 0; i < 17; i++) begin
      pulse((i == 16) ? PAT : {$urandom, $urandom, $urandom, $urandom});
      repeat (19) tick();
    end
    check("wrap_writes", 32'(wr_cnt - base), 272);
    check("wrap_cnt", 32'(blk_cnt), 1);
    check("wrap_img0", 32'(img[0]), 32'h00);
    check("wrap_imgF", 32'(img[15]), 32'hFF);

    // Abort at k=7 then a fresh block
    clr();
    pulse({$urandom, $urandom, $urandom, $urandom});
    repeat (7) tick();
    check("abort_k7", 32'(ram_addr), 32'h07);
    clr();
    check("abort_we", 32'(ram_we), 0);
    check("abort_cnt", 32'(blk_cnt), 0);
    pulse(PAT);
    repeat (20) tick();
    check("abort_img3", 32'(img[3]), 32'h33);
    check("abort_imgC", 32'(img[12]), 32'hCC);
    check("abort_cnt1", 32'(blk_cnt), 1);
`ifdef CT_XOR_CHECK_EN
    check("abort_chk", 32'(blk_chk), 32'h00);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      blk_valid = ($urandom_range(0, 3) == 0);
      blk_data  = {$urandom, $urandom, $urandom, $urandom};
      ptr_clr   = ($urandom_range(0, 96) == 0);
      ovf_clr   = ($urandom_range(0, 36) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    blk_valid = 1'b0; ptr_clr = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
